serial_addsub: RTL and testbench

//   Parametrised multi-cycle adder/subtractor. Successor to the combinational 4-bit ripple adder.

---
 rtl/serial_addsub.sv | 154 +++++++++++++++
 tb/tb_serial_addsub.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands consumed CHUNK bits per clock
// through a single registered carry, with signed overflow, zero flag and start/busy/done.
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic [1:0]       dbg_state   // 0 idle, 1 busy, 2 done
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    generate
        if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("serial_addsub: WIDTH must be >= 2 and a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Handshake: start is sampled only in IDLE or DONE; busy is high for the NCHUNK
    // processing cycles; done is a one-cycle pulse after which results are held until
    // the next accepted start. start during BUSY is dropped without side effects.

    // Reset asserts asynchronously but is released through two flops.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    state_t              r_state;
    state_t              w_state_next;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic                r_carry;
    logic [IDXW-1:0]     r_idx;
    logic [WIDTH-1:0]    r_sum;
    logic                r_cout;
    logic                r_ovf;
    logic                r_zero;

    logic                w_accept;
    logic                w_last;
    int                  w_base;
    logic [CHUNK-1:0]    w_a_chunk;
    logic [CHUNK-1:0]    w_b_chunk;
    logic [CHUNK:0]      w_chunk_sum;
    logic [CHUNK-1:0]    w_s;
    logic                w_c;
    logic [WIDTH-1:0]    w_sum_next;
    logic                w_ovf;

    assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last   = (r_idx == LAST_IDX);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_BUSY;
            S_BUSY:  if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = start ? S_BUSY : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_base      = int'(r_idx) * CHUNK;
        w_a_chunk   = r_a[w_base +: CHUNK];
        w_b_chunk   = r_b[w_base +: CHUNK];
        w_chunk_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
        w_s         = w_chunk_sum[CHUNK-1:0];
        w_c         = w_chunk_sum[CHUNK];
        w_sum_next  = r_sum;
        w_sum_next[w_base +: CHUNK] = w_s;
    end

    // On the last chunk, MSB sum = a ^ b' ^ carry_into_msb, so the carry into the MSB
    // is recovered from the operand and result MSBs without a separate bit chain.
    assign w_ovf = r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_s[CHUNK-1] ^ w_c;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub | cin;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else if (r_state == S_BUSY) begin
            r_sum   <= w_sum_next;
            r_carry <= w_c;
            r_idx   <= r_idx + 1'b1;
            if (w_last) begin
                r_cout <= w_c;
                r_ovf  <= w_ovf;
                r_zero <= (w_sum_next == '0);
            end
        end
    end

    assign busy      = (r_state == S_BUSY);
    assign done      = (r_state == S_DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign overflow  = r_ovf;
    assign zero      = r_zero;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: an 8-bit/1-bit instance and a 16-bit/4-bit instance,
// checked every cycle against an arithmetic model and a few literal results.
module tb_serial_addsub;

    localparam int N8  = 8;
    localparam int N16 = 4;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic        s8_start = 0, s8_sub = 0, s8_cin = 0;
    logic [7:0]  s8_a = 0, s8_b = 0;
    logic        o8_busy, o8_done, o8_cout, o8_ovf, o8_zero;
    logic [7:0]  o8_sum;
    logic [1:0]  o8_st;

    logic        s16_start = 0, s16_sub = 0, s16_cin = 0;
    logic [15:0] s16_a = 0, s16_b = 0;
    logic        o16_busy, o16_done, o16_cout, o16_ovf, o16_zero;
    logic [15:0] o16_sum;
    logic [1:0]  o16_st;

    serial_addsub #(.WIDTH(8), .CHUNK(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8_start), .sub(s8_sub), .a(s8_a), .b(s8_b),
        .cin(s8_cin), .busy(o8_busy), .done(o8_done), .sum(o8_sum), .cout(o8_cout),
        .overflow(o8_ovf), .zero(o8_zero), .dbg_state(o8_st)
    );

    serial_addsub #(.WIDTH(16), .CHUNK(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(s16_start), .sub(s16_sub), .a(s16_a), .b(s16_b),
        .cin(s16_cin), .busy(o16_busy), .done(o16_done), .sum(o16_sum), .cout(o16_cout),
        .overflow(o16_ovf), .zero(o16_zero), .dbg_state(o16_st)
    );

    // ---------------- scoreboard ----------------
    // entry: [63:32] cycle done is due, [18] zero, [17] overflow, [16] cout, [15:0] sum
    logic [63:0] exp8_q[$];
    logic [63:0] exp16_q[$];
    logic [18:0] held[2];
    logic [18:0] last_res[2];
    int          n_done[2];
    int          last_done_cyc[2];
    int          busy_cnt[2];
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic logic [18:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                          input logic sub, input logic cin);
        longint ua, ub, ci, full, modv, half, sa, sb, sres;
        logic [15:0] res;
        logic co, ov;
        modv = longint'(1) << w;
        half = modv / 2;
        ua = a;
        ub = b;
        ci = cin ? 1 : 0;
        if (sub) begin
            full = ua - ub;
            co   = (ua >= ub);
        end else begin
            full = ua + ub + ci;
            co   = (full >= modv);
        end
        res  = 16'(((full % modv) + modv) % modv);
        sa   = (ua >= half) ? ua - modv : ua;
        sb   = (ub >= half) ? ub - modv : ub;
        sres = sub ? sa - sb : sa + sb + ci;
        ov   = (sres >= half) || (sres < -half);
        return {res == 16'h0, ov, co, res};
    endfunction

    task automatic check_unit(input int u, input logic bsy, input logic dn,
                              input logic [1:0] st, input logic [18:0] outs);
        logic [63:0] front;
        bit have, eb, ed;
        int fd, n;
        string pfx;
        pfx = (u == 0) ? "w8" : "w16";
        n   = (u == 0) ? N8 : N16;
        if (!rst_n) begin
            chk({pfx, "_reset_outs"}, {41'b0, bsy, dn, st, outs}, 64'h0);
            if (u == 0) exp8_q.delete(); else exp16_q.delete();
            held[u] = '0;
            return;
        end
        if (bsy) busy_cnt[u]++;
        if (dn) begin
            n_done[u]++;
            last_done_cyc[u] = cyc;
            last_res[u] = outs;
        end
        have  = (u == 0) ? (exp8_q.size() > 0) : (exp16_q.size() > 0);
        front = '0;
        if (have) front = (u == 0) ? exp8_q[0] : exp16_q[0];
        fd = int'(front[63:32]);
        ed = have && (cyc == fd);
        eb = have && (cyc < fd) && (cyc >= fd - n);
        chk({pfx, "_busy"}, {63'b0, bsy}, {63'b0, eb});
        chk({pfx, "_done"}, {63'b0, dn}, {63'b0, ed});
        chk({pfx, "_state"}, {62'b0, st}, {62'b0, ed, eb});
        if (ed) begin
            chk({pfx, "_result"}, {45'b0, outs}, {45'b0, front[18:0]});
            held[u] = front[18:0];
        end
        if (have && cyc >= fd) begin
            if (u == 0) void'(exp8_q.pop_front()); else void'(exp16_q.pop_front());
        end
        if (!have) chk({pfx, "_hold"}, {45'b0, outs}, {45'b0, held[u]});
    endtask

    // single compare process for both instances
    always @(negedge clk) begin
        check_unit(0, o8_busy, o8_done, o8_st, {o8_zero, o8_ovf, o8_cout, 8'h00, o8_sum});
        check_unit(1, o16_busy, o16_done, o16_st, {o16_zero, o16_ovf, o16_cout, o16_sum});
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sub,
                        input logic cin, output int done_at);
        s8_a = a; s8_b = b; s8_sub = sub; s8_cin = cin; s8_start = 1'b1;
        @(posedge clk);
        #1;
        s8_start = 1'b0;
        s8_a = 8'($urandom); s8_b = 8'($urandom);
        s8_sub = 1'($urandom); s8_cin = 1'($urandom);
        done_at = cyc + N8;
        exp8_q.push_back({32'(done_at), 13'b0, model(8, {8'h00, a}, {8'h00, b}, sub, cin)});
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic sub,
                         input logic cin, output int done_at);
        s16_a = a; s16_b = b; s16_sub = sub; s16_cin = cin; s16_start = 1'b1;
        @(posedge clk);
        #1;
        s16_start = 1'b0;
        s16_a = 16'($urandom); s16_b = 16'($urandom);
        s16_sub = 1'($urandom); s16_cin = 1'($urandom);
        done_at = cyc + N16;
        exp16_q.push_back({32'(done_at), 13'b0, model(16, a, b, sub, cin)});
    endtask

    // leaves the caller inside the done cycle, after the compare process has run
    task automatic wait_done(input int done_at);
        while (cyc < done_at) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic lit8(input string name, input int nd_before, input logic [7:0] s,
                        input logic co, input logic ov, input logic z);
        chk({name, "_done_count"}, 64'(n_done[0]), 64'(nd_before + 1));
        chk(name, {45'b0, last_res[0]}, {45'b0, z, ov, co, 8'h00, s});
    endtask

    task automatic lit16(input string name, input int nd_before, input logic [15:0] s,
                         input logic co, input logic ov, input logic z);
        chk({name, "_done_count"}, 64'(n_done[1]), 64'(nd_before + 1));
        chk(name, {45'b0, last_res[1]}, {45'b0, z, ov, co, s});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int d, acc, nd, b0, prev;
        held[0] = '0; held[1] = '0;
        last_res[0] = '0; last_res[1] = '0;
        n_done[0] = 0; n_done[1] = 0;
        busy_cnt[0] = 0; busy_cnt[1] = 0;
        last_done_cyc[0] = 0; last_done_cyc[1] = 0;

        idle(3);
        chk("reset_state8", {51'b0, o8_busy, o8_done, o8_sum, o8_cout, o8_ovf, o8_zero}, 64'h0);
        rst_n = 1'b1;
        idle(4);

        // T1: plain add, latency and busy length
        nd = n_done[0]; b0 = busy_cnt[0];
        run8(8'h08, 8'h0F, 1'b0, 1'b0, d);
        acc = cyc;
        wait_done(d);
        lit8("t1_add", nd, 8'h17, 1'b0, 1'b0, 1'b0);
        chk("t1_latency", 64'(last_done_cyc[0] - acc), 64'd8);
        chk("t1_busy_cycles", 64'(busy_cnt[0] - b0), 64'd8);

        // T2: overflow and wrap to zero
        nd = n_done[0]; run8(8'h7F, 8'h01, 1'b0, 1'b0, d); wait_done(d);
        lit8("t2_ovf", nd, 8'h80, 1'b0, 1'b1, 1'b0);
        nd = n_done[0]; run8(8'hFF, 8'h01, 1'b0, 1'b0, d); wait_done(d);
        lit8("t2_wrap", nd, 8'h00, 1'b1, 1'b0, 1'b1);
        nd = n_done[0]; run8(8'h10, 8'h20, 1'b0, 1'b1, d); wait_done(d);
        lit8("t2_cin", nd, 8'h31, 1'b0, 1'b0, 1'b0);

        // T3: subtract (cin must be ignored)
        nd = n_done[0]; run8(8'h05, 8'h07, 1'b1, 1'b1, d); wait_done(d);
        lit8("t3_sub_borrow", nd, 8'hFE, 1'b0, 1'b0, 1'b0);
        nd = n_done[0]; run8(8'h80, 8'h01, 1'b1, 1'b0, d); wait_done(d);
        lit8("t3_sub_ovf", nd, 8'h7F, 1'b1, 1'b1, 1'b0);

        // T4: start while busy is ignored; start in done cycle gives back-to-back ops
        nd = n_done[0];
        run8(8'h33, 8'h44, 1'b0, 1'b0, d);
        idle(2);
        s8_a = 8'hAA; s8_b = 8'h55; s8_sub = 1'b1; s8_start = 1'b1;
        idle(1);
        s8_start = 1'b0;
        wait_done(d);
        lit8("t4_ignored_start", nd, 8'h77, 1'b0, 1'b0, 1'b0);
        prev = last_done_cyc[0];
        nd = n_done[0];
        run8(8'h10, 8'h01, 1'b1, 1'b0, d);
        wait_done(d);
        lit8("t4_b2b", nd, 8'h0F, 1'b1, 1'b0, 1'b0);
        chk("t4_b2b_gap", 64'(last_done_cyc[0] - prev), 64'd9);

        // T5: reset mid-operation aborts without a done
        nd = n_done[0];
        run8(8'h12, 8'h34, 1'b0, 1'b0, d);
        idle(4);
        rst_n = 1'b0;
        #1;
        chk("t5_reset_outs", {51'b0, o8_busy, o8_done, o8_sum, o8_cout, o8_ovf, o8_zero}, 64'h0);
        idle(2);
        rst_n = 1'b1;
        idle(5);
        chk("t5_no_done", 64'(n_done[0]), 64'(nd));
        nd = n_done[0]; run8(8'h12, 8'h34, 1'b0, 1'b0, d); wait_done(d);
        lit8("t5_after_reset", nd, 8'h46, 1'b0, 1'b0, 1'b0);

        // random 8-bit ops with stray starts during busy
        repeat (300) begin
            run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), d);
            if ($urandom_range(0, 1) == 1) begin
                idle($urandom_range(0, N8 - 2));
                s8_a = 8'($urandom); s8_b = 8'($urandom); s8_start = 1'b1;
                idle(1);
                s8_start = 1'b0;
            end
            wait_done(d);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        // T6: 16-bit, 4-bit chunks
        nd = n_done[1];
        run16(16'h1234, 16'h0FFF, 1'b0, 1'b0, d);
        acc = cyc;
        wait_done(d);
        lit16("t6_add16", nd, 16'h2233, 1'b0, 1'b0, 1'b0);
        chk("t6_latency", 64'(last_done_cyc[1] - acc), 64'd4);
        nd = n_done[1]; run16(16'h0001, 16'h0002, 1'b1, 1'b0, d); wait_done(d);
        lit16("t6_sub16", nd, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        nd = n_done[1]; run16(16'h8000, 16'h8000, 1'b0, 1'b0, d); wait_done(d);
        lit16("t6_ovf16", nd, 16'h0000, 1'b1, 1'b1, 1'b1);

        repeat (10000) begin
            run16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), d);
            wait_done(d);
            if ($urandom_range(0, 15) == 0) idle(1);
        end

        idle(3);
        chk("end_queue8_empty", 64'(exp8_q.size()), 64'd0);
        chk("end_queue16_empty", 64'(exp16_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // watchdog
    initial begin
        #3000000;
        errors++;
        $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
